compact_arbiter: RTL and testbench

// Shares one sparse-compaction engine among NREQ requesters. The engine packs the nonzero

---
 rtl/compact_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_compact_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compact_arbiter.sv
// Round-robin front end for a shared sparse-compaction engine: grants one requester,
// hands its vector to the engine, waits for done or timeout, and returns the packed result.
module compact_arbiter #(
  parameter int unsigned IL      = 8,
  parameter int unsigned FL      = 12,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ-1:0][15:0][IL+FL-1:0]     req_data,
  output logic [NREQ-1:0]                      gnt,
  output logic [15:0][IL+FL-1:0]               eng_i_im,
  output logic                                 eng_input_ready,
  input  logic [1:0]                           eng_state,
  input  logic [15:0][IL+FL-1:0]               eng_o_im,
  output logic                                 eng_output_taken,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [$clog2(NREQ)-1:0]              rsp_id,
  output logic [15:0][IL+FL-1:0]               rsp_data,
  output logic [4:0]                           rsp_nnz,
  output logic                                 rsp_err
);

  localparam int unsigned W     = IL + FL;
  localparam int unsigned IW    = $clog2(NREQ);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned LANES = 16;

  localparam logic [1:0] ENG_IDLE = 2'b00;
  localparam logic [1:0] ENG_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [IW-1:0]             own_q, own_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [NREQ-1:0]           gnt_q, gnt_d;
  logic [LANES-1:0][W-1:0]   eng_i_im_q, eng_i_im_d;
  logic                      eng_input_ready_q, eng_input_ready_d;
  logic                      eng_output_taken_q, eng_output_taken_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]             rsp_id_q, rsp_id_d;
  logic [LANES-1:0][W-1:0]   rsp_data_q, rsp_data_d;
  logic [4:0]                rsp_nnz_q, rsp_nnz_d;
  logic                      rsp_err_q, rsp_err_d;

  logic                      win_found_c;
  logic [IW-1:0]             win_idx_c;
  logic [IW-1:0]             cand_c;
  logic [4:0]                nnz_c;

  // Round-robin pick: first asserted request at or above the pointer, wrapping around
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_c = IW'((32'(ptr_q) + i) % NREQ);
      if (!win_found_c && req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Count of nonzero lanes in the engine result
  always_comb begin
    nnz_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (eng_o_im[i] != '0) nnz_c = nnz_c + 5'd1;
    end
  end

  // Next-state and registered-output logic for the grant/issue/wait/respond sequence
  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    own_d              = own_q;
    timer_d            = timer_q;
    gnt_d              = '0;
    eng_i_im_d         = eng_i_im_q;
    eng_input_ready_d  = 1'b0;
    eng_output_taken_d = 1'b0;
    rsp_valid_d        = rsp_valid_q;
    rsp_id_d           = rsp_id_q;
    rsp_data_d         = rsp_data_q;
    rsp_nnz_d          = rsp_nnz_q;
    rsp_err_d          = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (win_found_c && eng_state == ENG_IDLE) begin
          gnt_d[win_idx_c] = 1'b1;
          eng_i_im_d       = req_data[win_idx_c];
          own_d            = win_idx_c;
          ptr_d            = IW'((32'(win_idx_c) + 32'd1) % NREQ);
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_input_ready_d = 1'b1;
        timer_d           = '0;
        state_d           = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (eng_state == ENG_DONE) begin
          rsp_data_d         = eng_o_im;
          rsp_nnz_d          = nnz_c;
          rsp_err_d          = 1'b0;
          rsp_id_d           = own_q;
          rsp_valid_d        = 1'b1;
          eng_output_taken_d = 1'b1;
          state_d            = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_nnz_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = own_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      ptr_q              <= '0;
      own_q              <= '0;
      timer_q            <= '0;
      gnt_q              <= '0;
      eng_i_im_q         <= '0;
      eng_input_ready_q  <= 1'b0;
      eng_output_taken_q <= 1'b0;
      rsp_valid_q        <= 1'b0;
      rsp_id_q           <= '0;
      rsp_data_q         <= '0;
      rsp_nnz_q          <= '0;
      rsp_err_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      own_q              <= own_d;
      timer_q            <= timer_d;
      gnt_q              <= gnt_d;
      eng_i_im_q         <= eng_i_im_d;
      eng_input_ready_q  <= eng_input_ready_d;
      eng_output_taken_q <= eng_output_taken_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_id_q           <= rsp_id_d;
      rsp_data_q         <= rsp_data_d;
      rsp_nnz_q          <= rsp_nnz_d;
      rsp_err_q          <= rsp_err_d;
    end
  end

  assign gnt              = gnt_q;
  assign eng_i_im         = eng_i_im_q;
  assign eng_input_ready  = eng_input_ready_q;
  assign eng_output_taken = eng_output_taken_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_nnz          = rsp_nnz_q;
  assign rsp_err          = rsp_err_q;

endmodule

// File: tb/tb_compact_arbiter.sv
// Bench for compact_arbiter: engine model, transaction-level reference, directed tests.
module tb_compact_arbiter;

  localparam int unsigned IL = 8, FL = 12, W = 20, NREQ = 4, IW = 2, TIMEOUT = 64;
  localparam int unsigned VW = 16 * W;
  typedef logic [15:0][W-1:0] vec_t;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NREQ-1:0]           req = '0;
  logic [NREQ-1:0][15:0][W-1:0] req_data = '0;
  logic [NREQ-1:0]           gnt;
  vec_t                      eng_i_im;
  logic                      eng_input_ready;
  logic [1:0]                eng_state;
  vec_t                      eng_o_im;
  logic                      eng_output_taken;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [IW-1:0]             rsp_id;
  vec_t                      rsp_data;
  logic [4:0]                rsp_nnz;
  logic                      rsp_err;

  always #5 clk = ~clk;

  compact_arbiter #(.IL(IL), .FL(FL), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .eng_i_im(eng_i_im), .eng_input_ready(eng_input_ready), .eng_state(eng_state),
    .eng_o_im(eng_o_im), .eng_output_taken(eng_output_taken), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_nnz(rsp_nnz),
    .rsp_err(rsp_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic budget_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no event want event within cycle budget", nm);
  endtask

  // Pack nonzero lanes to the bottom, in order
  function automatic vec_t compact(input vec_t v);
    vec_t r;
    int n;
    r = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i] != '0) begin
        r[n] = v[i];
        n++;
      end
    end
    return r;
  endfunction

  function automatic int nz_count(input vec_t v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (v[i] != '0) n++;
    return n;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return 0;
  endfunction

  // Engine model: start on input_ready, busy for eng_lat cycles (or forever if stuck), done until taken
  bit eng_stuck = 1'b0;
  int eng_lat = 2;
  int eng_cnt;
  always @(posedge clk) begin
    if (reset) begin
      eng_state <= 2'b00;
      eng_cnt   <= 0;
      eng_o_im  <= '0;
    end else begin
      case (eng_state)
        2'b00: if (eng_input_ready) begin
          eng_state <= 2'b01;
          eng_cnt   <= eng_lat;
        end
        2'b01: if (!eng_stuck) begin
          if (eng_cnt == 0) begin
            eng_state <= 2'b10;
            eng_o_im  <= compact(eng_i_im);
          end else begin
            eng_cnt <= eng_cnt - 1;
          end
        end
        2'b10: if (eng_output_taken) eng_state <= 2'b00;
        default: eng_state <= 2'b00;
      endcase
    end
  end

  // Reference: transaction progress (free / granted / engine running / replying)
  int   m_stage, m_ptr, m_id, m_wait, k;
  logic [NREQ-1:0] e_gnt;
  vec_t e_iim, e_data;
  logic e_ir, e_ot, e_rv, e_err;
  logic [IW-1:0] e_id;
  logic [4:0] e_nnz;
  logic p_reset, p_ready;
  logic [NREQ-1:0] p_req;
  logic [NREQ-1:0][15:0][W-1:0] p_data;
  logic [1:0] p_es;
  bit armed = 1'b0;
  int gnt_log[$];
  int ir_cnt = 0;
  int ot_cnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      if (p_reset) begin
        m_stage = 0; m_ptr = 0; m_id = 0; m_wait = 0;
        e_gnt = '0; e_iim = '0; e_ir = 0; e_ot = 0; e_rv = 0;
        e_id = '0; e_data = '0; e_nnz = '0; e_err = 0;
      end else begin
        e_gnt = '0; e_ir = 0; e_ot = 0;
        case (m_stage)
          0: if (p_req != '0 && p_es == 2'b00) begin
            k = rr_pick(p_req, m_ptr);
            e_gnt[k] = 1'b1;
            e_iim = p_data[k];
            m_id = k;
            m_ptr = (k + 1) % NREQ;
            m_stage = 1;
          end
          1: begin
            e_ir = 1; m_wait = 0; m_stage = 2;
          end
          2: if (p_es == 2'b10) begin
            e_ot = 1; e_rv = 1; e_id = IW'(m_id);
            e_data = compact(e_iim); e_nnz = 5'(nz_count(e_iim)); e_err = 0;
            m_stage = 3;
          end else if (m_wait == TIMEOUT - 1) begin
            e_rv = 1; e_id = IW'(m_id); e_data = '0; e_nnz = '0; e_err = 1;
            m_stage = 3;
          end else begin
            m_wait++;
          end
          default: if (p_ready) begin
            e_rv = 0; m_stage = 0;
          end
        endcase
      end
      chk("gnt", VW'(gnt), VW'(e_gnt));
      chk("eng_i_im", VW'(eng_i_im), VW'(e_iim));
      chk("eng_input_ready", VW'(eng_input_ready), VW'(e_ir));
      chk("eng_output_taken", VW'(eng_output_taken), VW'(e_ot));
      chk("rsp_valid", VW'(rsp_valid), VW'(e_rv));
      chk("rsp_id", VW'(rsp_id), VW'(e_id));
      chk("rsp_data", VW'(rsp_data), VW'(e_data));
      chk("rsp_nnz", VW'(rsp_nnz), VW'(e_nnz));
      chk("rsp_err", VW'(rsp_err), VW'(e_err));
      for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) gnt_log.push_back(i);
      if (eng_input_ready === 1'b1) ir_cnt++;
      if (eng_output_taken === 1'b1) ot_cnt++;
    end
    if (reset === 1'b1) armed = 1'b1;
    p_reset = reset;
    p_req   = req;
    p_data  = req_data;
    p_es    = eng_state;
    p_ready = rsp_ready;
  end

  // Stimulus helpers; requesters drop req on their own grant unless hold is set
  bit hold = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold) req = req & ~gnt;
  endtask

  task automatic wait_gnt(input string nm);
    int n;
    n = 0;
    do begin tick(); n++; end while (gnt == '0 && n < 50);
    if (gnt == '0) budget_fail(nm);
  endtask

  task automatic wait_rsp(input string nm, input int budget);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin tick(); n++; end
    if (rsp_valid !== 1'b1) budget_fail(nm);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  vec_t v1, vz, vall, v15, vb;
  int g0, ir0, ot0, n;
  int exp_order[5];

  initial begin
    v1 = '0; v1[1] = 20'd5; v1[3] = 20'hFFFFD;
    vz = '0;
    for (int i = 0; i < 16; i++) vall[i] = (i % 2 == 1) ? 20'(-(i + 1)) : 20'(i + 1);
    v15 = '0; v15[15] = 20'h00ABC;
    vb = '0; vb[2] = 20'h12345; vb[9] = 20'h80000; vb[14] = 20'h00001;

    // Reset values
    do_reset();
    chk("reset_rsp_valid", VW'(rsp_valid), VW'(1'b0));
    chk("reset_gnt", VW'(gnt), VW'(4'b0000));
    chk("reset_rsp_nnz", VW'(rsp_nnz), VW'(5'd0));

    // Single request from requester 2
    req_data[2] = v1;
    req = 4'b0100;
    wait_gnt("t1_gnt_wait");
    chk("t1_gnt", VW'(gnt), VW'(4'b0100));
    wait_rsp("t1_rsp_wait", 40);
    chk("t1_rsp_id", VW'(rsp_id), VW'(2'd2));
    chk("t1_lane0", VW'(rsp_data[0]), VW'(20'd5));
    chk("t1_lane1", VW'(rsp_data[1]), VW'(20'hFFFFD));
    chk("t1_lane2", VW'(rsp_data[2]), VW'(20'd0));
    chk("t1_nnz", VW'(rsp_nnz), VW'(5'd2));
    chk("t1_err", VW'(rsp_err), VW'(1'b0));
    tick(); tick();

    // All four requesting continuously from pointer 0
    do_reset();
    req_data[0] = v1; req_data[1] = v15; req_data[2] = vall; req_data[3] = vb;
    g0 = gnt_log.size(); ir0 = ir_cnt; ot0 = ot_cnt;
    hold = 1'b1;
    req = 4'b1111;
    n = 0;
    while (gnt_log.size() < g0 + 5 && n < 400) begin tick(); n++; end
    req = '0;
    hold = 1'b0;
    if (gnt_log.size() < g0 + 5) budget_fail("t2_grants");
    else begin
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) chk("t2_order", VW'(gnt_log[g0 + i]), VW'(exp_order[i]));
    end
    wait_rsp("t2_rsp_wait", 60);
    tick(); tick(); tick();
    chk("t2_input_ready_count", VW'(ir_cnt - ir0), VW'(5));
    chk("t2_output_taken_count", VW'(ot_cnt - ot0), VW'(5));

    // All-zero vector, then all-nonzero vector
    req_data[0] = vz;
    req = 4'b0001;
    wait_rsp("t3_rsp_wait", 40);
    chk("t3_zero_nnz", VW'(rsp_nnz), VW'(5'd0));
    chk("t3_zero_data", VW'(rsp_data), VW'(vz));
    tick(); tick();
    req_data[3] = vall;
    req = 4'b1000;
    wait_rsp("t3b_rsp_wait", 40);
    chk("t3_full_nnz", VW'(rsp_nnz), VW'(5'd16));
    chk("t3_full_data", VW'(rsp_data), VW'(vall));
    chk("t3_full_id", VW'(rsp_id), VW'(2'd3));
    tick(); tick();

    // Response backpressure for 20 cycles with another requester waiting
    rsp_ready = 1'b0;
    req_data[1] = vb;
    req = 4'b0010;
    wait_rsp("t4_rsp_wait", 40);
    req_data[0] = v15;
    req[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold_valid", VW'(rsp_valid), VW'(1'b1));
      chk("t4_hold_data", VW'(rsp_data), VW'(compact(vb)));
      chk("t4_no_gnt", VW'(gnt), VW'(4'b0000));
      chk("t4_no_start", VW'(eng_input_ready), VW'(1'b0));
    end
    rsp_ready = 1'b1;
    wait_gnt("t4_gnt_wait");
    chk("t4_next_gnt", VW'(gnt), VW'(4'b0001));
    wait_rsp("t4b_rsp_wait", 40);
    chk("t4_next_data", VW'(rsp_data), VW'(compact(v15)));
    tick(); tick();

    // Engine stuck busy: timeout response, no release pulse
    eng_stuck = 1'b1;
    ot0 = ot_cnt;
    req_data[2] = v1;
    req = 4'b0100;
    wait_rsp("t5_rsp_wait", 200);
    chk("t5_err", VW'(rsp_err), VW'(1'b1));
    chk("t5_nnz", VW'(rsp_nnz), VW'(5'd0));
    chk("t5_data", VW'(rsp_data), VW'(vz));
    chk("t5_id", VW'(rsp_id), VW'(2'd2));
    tick(); tick(); tick();
    chk("t5_no_taken", VW'(ot_cnt - ot0), VW'(0));
    do_reset();
    eng_stuck = 1'b0;

    // Reset while the engine is running, then a fresh request from pointer 0
    eng_lat = 10;
    req_data[1] = vb;
    req = 4'b0010;
    n = 0;
    while (eng_input_ready !== 1'b1 && n < 40) begin tick(); n++; end
    if (eng_input_ready !== 1'b1) budget_fail("t6_start_wait");
    tick(); tick();
    reset = 1'b1;
    req = '0;
    tick();
    reset = 1'b0;
    chk("t6_rst_valid", VW'(rsp_valid), VW'(1'b0));
    chk("t6_rst_gnt", VW'(gnt), VW'(4'b0000));
    chk("t6_rst_iim", VW'(eng_i_im), VW'(vz));
    eng_lat = 2;
    req_data[1] = v15; req_data[3] = v1;
    req = 4'b1010;
    wait_gnt("t6_gnt_wait");
    chk("t6_gnt", VW'(gnt), VW'(4'b0010));
    wait_rsp("t6_rsp_wait", 40);
    chk("t6_rsp_id", VW'(rsp_id), VW'(2'd1));
    chk("t6_rsp_data", VW'(rsp_data), VW'(compact(v15)));
    chk("t6_rsp_nnz", VW'(rsp_nnz), VW'(5'd1));
    tick(); tick();
    req = 4'b0000;
    wait_rsp("t6b_rsp_wait", 40);
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule
